// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction-fetch stage feeding pipeline_decode.
//
// Holds the fetch PC, issues one 64-bit-aligned read at a time to instruction
// memory and presents the 32-bit word selected by pc[2] to decode until decode
// is ready. Redirects from execute replace the PC and drop any in-flight data.
// An all-zero instruction is the bubble encoding.
//
// Optional feature: define FETCH_WORD_REUSE_EN to keep the last fetched line so
// the upper word of a line is presented without a second memory request.
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_next_stage_ready  decode consumes the presented instruction
//   i_redirect_valid    execute requests a PC change this cycle
//   i_redirect_pc       new fetch PC (bits [1:0] ignored)
//   o_mem_req_valid     read request valid
//   i_mem_req_ready     memory accepts the request
//   o_mem_req_addr      line-aligned read address
//   i_mem_resp_valid    read data valid (one per accepted request, in order)
//   i_mem_resp_data     read data; [31:0] word at addr, [63:32] word at addr+4
//   o_instruction       instruction to decode, 0 = bubble
//   o_instruction_pc    PC of o_instruction

module pipeline_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_next_stage_ready,
    input  logic                    i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   i_redirect_pc,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
    input  logic                    i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_resp_data,
    output logic [DATA_WIDTH/2-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]   o_instruction_pc
);

    localparam int unsigned IW = DATA_WIDTH / 2;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StOut   = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [IW-1:0]         r_instr;
    logic [ADDR_WIDTH-1:0] r_instr_pc;

    logic [2:0]            w_state_d;
    logic [ADDR_WIDTH-1:0] w_pc_d;
    logic [IW-1:0]         w_instr_d;
    logic [ADDR_WIDTH-1:0] w_ipc_d;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_outstanding;
    logic                  w_unused_redirect_lo;

    // Low redirect bits are architecturally ignored.
    assign w_unused_redirect_lo = ^i_redirect_pc[1:0];

    assign w_pc_inc = r_fetch_pc + ADDR_WIDTH'(4);

    // A request is still owed a response after this edge.
    assign w_outstanding = ((r_state == StWait)  && !i_mem_resp_valid) ||
                           ((r_state == StReq)   &&  i_mem_req_ready)  ||
                           ((r_state == StDrain) && !i_mem_resp_valid);

`ifdef FETCH_WORD_REUSE_EN
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-4:0] r_buf_line;
    logic [IW-1:0]         r_buf_hi;
    logic                  w_reuse_hit;

    // The instruction in OUT came from the buffered line when pc[2] is 0,
    // so its upper half is exactly the next sequential instruction.
    assign w_reuse_hit = r_buf_valid && !r_fetch_pc[2] &&
                         (r_buf_line == r_fetch_pc[ADDR_WIDTH-1:3]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_line  <= '0;
            r_buf_hi    <= '0;
        end else if (i_redirect_valid) begin
            r_buf_valid <= 1'b0;
        end else if ((r_state == StWait) && i_mem_resp_valid) begin
            r_buf_valid <= 1'b1;
            r_buf_line  <= r_fetch_pc[ADDR_WIDTH-1:3];
            r_buf_hi    <= i_mem_resp_data[DATA_WIDTH-1:IW];
        end
    end
`endif

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_fetch_pc;
        w_instr_d = r_instr;
        w_ipc_d   = r_instr_pc;

        unique case (r_state)
            StIdle: w_state_d = StReq;
            StReq: begin
                if (i_mem_req_ready) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_resp_valid) begin
                    w_instr_d = r_fetch_pc[2] ? i_mem_resp_data[DATA_WIDTH-1:IW]
                                              : i_mem_resp_data[IW-1:0];
                    w_ipc_d   = r_fetch_pc;
                    w_state_d = StOut;
                end
            end
            StOut: begin
                if (i_next_stage_ready) begin
                    w_pc_d = w_pc_inc;
`ifdef FETCH_WORD_REUSE_EN
                    if (w_reuse_hit) begin
                        w_instr_d = r_buf_hi;
                        w_ipc_d   = w_pc_inc;
                    end else begin
                        w_instr_d = '0;
                        w_state_d = StReq;
                    end
`else
                    w_instr_d = '0;
                    w_state_d = StReq;
`endif
                end
            end
            StDrain: begin
                if (i_mem_resp_valid) begin
                    w_state_d = StReq;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Redirect overrides everything, including a same-cycle consume in OUT.
        if (i_redirect_valid) begin
            w_pc_d    = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            w_instr_d = '0;
            w_ipc_d   = '0;
            w_state_d = w_outstanding ? StDrain : StReq;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_fetch_pc <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_pc_d;
            r_instr    <= w_instr_d;
            r_instr_pc <= w_ipc_d;
        end
    end

    assign o_mem_req_valid  = (r_state == StReq);
    assign o_mem_req_addr   = {r_fetch_pc[ADDR_WIDTH-1:3], 3'b000};
    assign o_instruction    = r_instr;
    assign o_instruction_pc = r_instr_pc;

endmodule

// File: doc/pipeline_fetch.md
# pipeline_fetch

Instruction-fetch stage directly upstream of `pipeline_decode`. Holds the architectural fetch PC, issues one 64-bit-aligned read at a time to instruction memory, and selects the 32-bit instruction by `pc[2]`. It presents `instruction`/`instruction_pc` to decode until decode's `ready` is high, and takes PC redirects from execute, discarding any in-flight response. An all-zero `instruction` is the bubble encoding that decode treats as NOP.

## Interface
- `ADDR_WIDTH`, 64, PC and memory address width.
- `DATA_WIDTH`, 64, memory data width; instruction width is `DATA_WIDTH/2`.
- `RESET_PC`, 0, first fetch address; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `next_stage_ready`  in  1  decode `ready`; consumes the presented instruction.
- `redirect_valid`  in  1  execute requests PC change this cycle.
- `redirect_pc`  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored and treated as 0.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  ADDR_WIDTH  `{fetch_pc[ADDR_WIDTH-1:3], 3'b000}`.
- `mem_resp_valid`  in  1  read data valid; one response per accepted request, in order.
- `mem_resp_data`  in  DATA_WIDTH  read data; [31:0] = word at `addr`, [63:32] = word at `addr+4`.
- `instruction`  out  DATA_WIDTH/2  instruction to decode; 0 = bubble.
- `instruction_pc`  out  ADDR_WIDTH  PC of `instruction`.

## Operation
- States: IDLE, REQ, WAIT, OUT, DRAIN. Only one request is outstanding at a time.
- IDLE: entered on reset; moves to REQ on the first clock edge after reset deasserts.
- REQ: `mem_req_valid`=1, `mem_req_addr` from `fetch_pc`. If `mem_req_ready`, go to WAIT.
- WAIT: on `mem_resp_valid`:
  - `instruction` <= `pc[2] ? data[63:32] : data[31:0]`.
  - `instruction_pc` <= `fetch_pc`.
  - Go to OUT.
- OUT: hold `instruction`/`instruction_pc` stable. If `next_stage_ready`:
  - `fetch_pc` += 4, modulo 2^ADDR_WIDTH (wraps to 0).
  - `instruction` <= 0.
  - Go to REQ.
- Redirect (highest priority, any state):
  - `fetch_pc` <= `{redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
  - `instruction` <= 0, `instruction_pc` <= 0.
  - Next state is DRAIN if a request is outstanding after this edge; otherwise REQ.
  - Outstanding means: in WAIT without `mem_resp_valid`, or in REQ with `mem_req_ready`, or in DRAIN without `mem_resp_valid`.
  - A response arriving in the redirect cycle is discarded.
- DRAIN: `mem_req_valid`=0. On `mem_resp_valid`, discard the data and go to REQ.
- Redirect in OUT with `next_stage_ready` in the same cycle: decode consumed the instruction. Redirect still wins the PC update; there is no +4.
- `mem_resp_valid` in IDLE/REQ/OUT: ignored.

## Timing
- Reset values:
  - `mem_req_valid`=0, `mem_req_addr`=`RESET_PC`.
  - `instruction`=0, `instruction_pc`=0.
  - `fetch_pc`=`RESET_PC`, state IDLE.
- `mem_req_valid`/`mem_req_addr` are decoded from registered state and `fetch_pc` only; there are no combinational paths from inputs.
- Latency: instruction visible on the edge after the `mem_resp_valid` cycle.
- Steady state with zero-wait memory (`mem_req_ready`=1, response the cycle after accept, decode always ready): one instruction per 3 cycles.
- Back-to-back redirects: the last one wins. DRAIN still discards exactly one response.
- Async reset mid-WAIT/DRAIN: state returns to IDLE. The memory side must also be reset; a stale response arriving before the REQ state is ignored.

## Configuration
- `FETCH_WORD_REUSE_EN` defined:
  - The last response word and its line address are kept in a buffer.
  - In OUT with `next_stage_ready`, if the old PC had `pc[2]`=0 and the buffer is valid, the upper half loads directly as the next `instruction` with PC+4. State stays OUT; no request is issued; back-to-back issue, 1/cycle.
  - The buffer is invalidated by reset and by redirect.
- Not defined: no buffer; every PC issues a memory request.

## Test plan
- Reset release, `RESET_PC`=0x1000, memory returns 0x00000793_fe010113 → `mem_req_addr`=0x1000; `instruction`=0xfe010113 with PC 0x1000, then 0x00000793 with PC 0x1004 after a second request to 0x1000 (one request only when `FETCH_WORD_REUSE_EN` is defined).
- Decode stalls (`next_stage_ready`=0) for 5 cycles in OUT → `instruction`/`instruction_pc` stable, `mem_req_valid`=0, no PC advance.
- Redirect to 0x2006 during WAIT, response arrives 2 cycles later → response discarded; next `mem_req_addr`=0x2000; `instruction` taken from bits [63:32] with PC 0x2004.
- Redirect coincident with `mem_resp_valid` in WAIT → no DRAIN; next cycle REQ to the redirect target; old data never appears on `instruction`.
- `fetch_pc`=0xFFFF_FFFF_FFFF_FFFC consumed → next `mem_req_addr`=0.
- Async reset asserted mid-WAIT → all outputs 0 immediately; fetch restarts at `RESET_PC`.
